histogram_accumulator: RTL and testbench

HISTOGRAM_ACCUMULATOR -- requirements
Module: histogram_accumulator

---
 rtl/histo_pkg.sv | 15 +
 rtl/histo_bank_ram.sv | 30 +++
 rtl/histogram_accumulator.sv | 132 +++++++++++++
 tb/tb_histogram_accumulator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/histo_pkg.sv
// Shared sizing and FSM encoding for the histogram accumulator.
package histo_pkg;

  localparam int unsigned HISTO_CNT_W = 20;
  localparam int unsigned HISTO_NBINS = 256;
  localparam int unsigned HISTO_AW    = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/histo_bank_ram.sv
// One histogram bank: synchronous read-first read port plus one write port.
module histo_bank_ram
  import histo_pkg::*;
#(
  parameter int unsigned W     = HISTO_CNT_W,
  parameter int unsigned DEPTH = HISTO_NBINS,
  parameter int unsigned AW    = HISTO_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Array contents are zeroed by the owner's sweep, never by reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_rdata <= '0;
    else       o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Double-banked pixel histogram: one bank accumulates while the other is
// displayed; banks swap at frame end after the increment pipeline drains.
module histogram_accumulator
  import histo_pkg::*;
#(
  parameter int unsigned CNT_W = HISTO_CNT_W,
  parameter int unsigned NBINS = HISTO_NBINS
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [7:0]       iPixel,
  input  logic             iValid,
  input  logic             iFrameEnd,
  output logic             oReady,
  input  logic [7:0]       iHistoAddr,
  output logic [CNT_W-1:0] oHistoValue,
  output logic             oFrameDone,
  output logic             oSat
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       LAST_ADDR = 8'(NBINS - 1);

  state_e           r_state, w_state_nxt;
  logic             w_swap;
  logic [7:0]       r_addr;
  logic             r_sel, r_dsel;
  logic             r_ready, r_done, r_sat;
  logic             r_v1;
  logic [7:0]       r_a1;
  logic             r_wv;
  logic [7:0]       r_wa;
  logic [CNT_W-1:0] r_wd;

  logic             w_accept, w_sweep, w_sat_hit;
  logic [CNT_W-1:0] w_rd0, w_rd1, w_acc_rd, w_cur, w_inc, w_wdata;
  logic [7:0]       w_waddr, w_raddr0, w_raddr1;
  logic             w_we0, w_we1;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      ST_INIT:  if (r_addr == LAST_ADDR) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (iFrameEnd) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (!r_v1) begin
        w_state_nxt = ST_CLEAR;
        w_swap      = 1'b1;
      end
      ST_CLEAR: if (r_addr == LAST_ADDR) w_state_nxt = ST_ACCUM;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Stage 1 increment; the previous cycle's write is forwarded because the
  // RAM read for this pixel was issued in the same cycle that write landed.
  always_comb begin
    w_accept  = iValid & r_ready;
    w_sweep   = (r_state == ST_INIT) || (r_state == ST_CLEAR);
    w_acc_rd  = r_sel ? w_rd1 : w_rd0;
    w_cur     = (r_wv && (r_wa == r_a1)) ? r_wd : w_acc_rd;
    w_sat_hit = r_v1 && (w_cur == CNT_MAX);
    w_inc     = (w_cur == CNT_MAX) ? w_cur : w_cur + CNT_W'(1);
    w_wdata   = w_sweep ? '0 : w_inc;
    w_waddr   = w_sweep ? r_addr : r_a1;
    w_we0     = (r_state == ST_INIT) || (!r_sel && ((r_state == ST_CLEAR) || r_v1));
    w_we1     = (r_state == ST_INIT) || ( r_sel && ((r_state == ST_CLEAR) || r_v1));
    w_raddr0  = r_sel ? iHistoAddr : iPixel;
    w_raddr1  = r_sel ? iPixel : iHistoAddr;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_addr  <= '0;
      r_sel   <= 1'b0;
      r_dsel  <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      r_v1    <= 1'b0;
      r_a1    <= '0;
      r_wv    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
    end else begin
      r_addr  <= w_sweep ? r_addr + 8'd1 : 8'd0;
      r_sel   <= r_sel ^ w_swap;
      r_dsel  <= ~r_sel;
      r_ready <= (w_state_nxt == ST_ACCUM);
      r_done  <= w_swap;
      if (w_swap)         r_sat <= 1'b0;
      else if (w_sat_hit) r_sat <= 1'b1;
      r_v1    <= w_accept;
      r_a1    <= iPixel;
      r_wv    <= r_v1;
      r_wa    <= r_a1;
      r_wd    <= w_inc;
    end
  end

  histo_bank_ram #(.W(CNT_W), .DEPTH(NBINS), .AW(HISTO_AW)) u_bank0 (
    .i_clk   (iClk),
    .i_rst   (iRst),
    .i_we    (w_we0),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr0),
    .o_rdata (w_rd0)
  );

  histo_bank_ram #(.W(CNT_W), .DEPTH(NBINS), .AW(HISTO_AW)) u_bank1 (
    .i_clk   (iClk),
    .i_rst   (iRst),
    .i_we    (w_we1),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr1),
    .o_rdata (w_rd1)
  );

  // Display select is the registered complement of the bank-select used at read time.
  assign oHistoValue = r_dsel ? w_rd1 : w_rd0;
  assign oReady      = r_ready;
  assign oFrameDone  = r_done;
  assign oSat        = r_sat;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed bench: a wide-count and a 4-bit-count instance share all stimulus.
module tb_histogram_accumulator;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [7:0]  iPixel;
  logic        iValid;
  logic        iFrameEnd;
  logic [7:0]  iHistoAddr;
  logic        oReady, oFrameDone, oSat;
  logic [19:0] oHistoValue;
  logic        oReady_s, oFrameDone_s, oSat_s;
  logic [3:0]  oHistoValue_s;

  int n_cmp  = 0;
  int n_fail = 0;
  int acc  [256];
  int disp [256];
  int exp_q[$];

  always #5 iClk = ~iClk;

  histogram_accumulator #(.CNT_W(20), .NBINS(256)) u_dut (
    .iClk(iClk), .iRst(iRst), .iPixel(iPixel), .iValid(iValid),
    .iFrameEnd(iFrameEnd), .oReady(oReady), .iHistoAddr(iHistoAddr),
    .oHistoValue(oHistoValue), .oFrameDone(oFrameDone), .oSat(oSat)
  );

  histogram_accumulator #(.CNT_W(4), .NBINS(256)) u_sat (
    .iClk(iClk), .iRst(iRst), .iPixel(iPixel), .iValid(iValid),
    .iFrameEnd(iFrameEnd), .oReady(oReady_s), .iHistoAddr(iHistoAddr),
    .oHistoValue(oHistoValue_s), .oFrameDone(oFrameDone_s), .oSat(oSat_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      acc[i]  = 0;
      disp[i] = 0;
    end
  endtask

  task automatic send(input int p);
    iValid = 1'b1;
    iPixel = 8'(p);
    acc[p]++;
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic read_bin(input int a);
    int e;
    iHistoAddr = 8'(a);
    exp_q.push_back(disp[a]);
    @(negedge iClk);
    e = exp_q.pop_front();
    check($sformatf("bin%0d wide", a), 32'(oHistoValue), 32'(e));
    check($sformatf("bin%0d narrow", a), 32'(oHistoValue_s), 32'((e > 15) ? 15 : e));
  endtask

  // Counts cycles until ready; optionally throws pixels and a frame end at the busy DUT.
  task automatic wait_ready(input string tag, input bit junk);
    int n;
    bit extra_done;
    n = 0;
    extra_done = 1'b0;
    while (oReady !== 1'b1 && n < 400) begin
      if (junk) begin
        iValid    = 1'b1;
        iPixel    = 8'd42;
        iFrameEnd = (n == 10);
      end
      @(negedge iClk);
      n++;
      if (oFrameDone === 1'b1 || oFrameDone_s === 1'b1) extra_done = 1'b1;
    end
    iValid    = 1'b0;
    iFrameEnd = 1'b0;
    check({tag, " ready latency"}, 32'(n), 32'd256);
    check({tag, " narrow ready"}, 32'(oReady_s), 32'd1);
    check({tag, " no extra done"}, 32'(extra_done), 32'd0);
  endtask

  task automatic end_frame(input bit with_px, input int p, input bit sat_w, input bit sat_n);
    int n;
    iFrameEnd = 1'b1;
    if (with_px) begin
      iValid = 1'b1;
      iPixel = 8'(p);
      acc[p]++;
    end
    @(negedge iClk);
    iFrameEnd = 1'b0;
    iValid    = 1'b0;
    check("flush ready", 32'(oReady), 32'd0);
    check("sat wide pre-swap", 32'(oSat), 32'(sat_w));
    check("sat narrow pre-swap", 32'(oSat_s), 32'(sat_n));
    n = 0;
    while (oFrameDone !== 1'b1 && n < 8) begin
      @(negedge iClk);
      n++;
    end
    check("frame done wide", 32'(oFrameDone), 32'd1);
    check("frame done narrow", 32'(oFrameDone_s), 32'd1);
    check("flush cycles", 32'(n <= 2), 32'd1);
    check("sat wide cleared", 32'(oSat), 32'd0);
    check("sat narrow cleared", 32'(oSat_s), 32'd0);
    disp = acc;
    for (int i = 0; i < 256; i++) acc[i] = 0;
  endtask

  initial begin
    iRst = 1'b0; iPixel = '0; iValid = 1'b0; iFrameEnd = 1'b0; iHistoAddr = '0;
    clear_model();
    #2 iRst = 1'b1;
    repeat (3) @(negedge iClk);
    check("reset ready", 32'(oReady), 32'd0);
    check("reset done", 32'(oFrameDone), 32'd0);
    check("reset sat", 32'(oSat), 32'd0);
    check("reset histo", 32'(oHistoValue), 32'd0);
    iRst = 1'b0;
    wait_ready("init", 1'b0);
    for (int a = 0; a < 256; a++) read_bin(a);

    // Frame 1: one bin hammered back to back.
    for (int i = 0; i < 1000; i++) send(7);
    end_frame(1'b0, 0, 1'b0, 1'b1);
    wait_ready("clear1", 1'b0);
    for (int a = 0; a < 256; a++) read_bin(a);

    // Frame 2: interleaved repeats, last pixel shares the frame-end cycle.
    for (int r = 0; r < 100; r++) begin
      send(3); send(3); send(5); send(3); send(5);
      if (r != 99) send(5);
    end
    end_frame(1'b1, 5, 1'b0, 1'b1);
    wait_ready("clear2 junk", 1'b1);
    read_bin(3); read_bin(5); read_bin(7); read_bin(42); read_bin(0); read_bin(255);

    // Frame 3: saturation of the narrow instance.
    for (int i = 0; i < 20; i++) send(9);
    end_frame(1'b0, 0, 1'b0, 1'b1);
    wait_ready("clear3", 1'b0);
    read_bin(9); read_bin(42); read_bin(3); read_bin(8); read_bin(10);

    // Reset mid-frame discards the partial histogram.
    for (int i = 0; i < 50; i++) send(1);
    check("pre-reset narrow sat", 32'(oSat_s), 32'd1);
    iRst = 1'b1;
    @(negedge iClk);
    check("mid reset ready", 32'(oReady), 32'd0);
    check("mid reset sat narrow", 32'(oSat_s), 32'd0);
    check("mid reset histo", 32'(oHistoValue), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    clear_model();
    wait_ready("init2", 1'b0);
    read_bin(1); read_bin(9);
    for (int i = 0; i < 10; i++) send(1);
    end_frame(1'b0, 0, 1'b0, 1'b0);
    read_bin(1); read_bin(9); read_bin(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
